// File: rtl/uart_pkg.sv
// Shared configuration constants for the UART: baud divisor, address window,
// FSM state encoding shared by TX and RX, and status-word field positions.
package configure;

    localparam int unsigned clks_per_bit   = 172;
    localparam logic [31:0] uart_base_addr = 32'h8000_0000;
    localparam logic [31:0] uart_top_addr  = 32'h8000_0003;

    localparam int unsigned cnt_w = $clog2(clks_per_bit + 1);
    localparam logic [cnt_w-1:0] bit_last = cnt_w'(clks_per_bit);
    localparam logic [cnt_w-1:0] bit_half = cnt_w'(clks_per_bit / 2);

    localparam int RXV = 8;
    localparam int TXB = 9;
    localparam int OVR = 10;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchroniser on rx followed by an 8N1 deframer.
// Emits the received byte with a one-cycle done pulse on a valid stop bit.
module uart_rx
    import configure::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       done
);

    logic             sync_a, sync_b, sync_prev;
    uart_state_t      state, state_next;
    logic [cnt_w-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic [7:0]       data_next;
    logic             done_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            sync_prev <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            done      <= 1'b0;
        end else begin
            sync_a    <= rx;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            data      <= data_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        data_next    = data;
        done_next    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                // Only a falling edge starts a frame, so a line held low
                // after a framing error does not retrigger.
                if (sync_prev && !sync_b) state_next = START;
            end
            START: begin
                if (cnt == bit_half) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = sync_b ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == bit_last) begin
                    cnt_next     = '0;
                    shift_next   = {sync_b, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == bit_last) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (sync_b) begin
                        done_next = 1'b1;
                        data_next = shift;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart.sv
// Memory-mapped 8N1 UART: bus handshake, status register and TX serialiser,
// with the receive path delegated to uart_rx.
module uart
    import configure::*;
(
    input  logic        reset,
    input  logic        clock,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    input  logic        uart_rx,
    output logic        uart_tx
);

    uart_state_t      tx_state, tx_state_next;
    logic [cnt_w-1:0] tx_cnt, tx_cnt_next;
    logic [2:0]       tx_bit, tx_bit_next;
    logic [7:0]       tx_shift, tx_shift_next;
    logic             tx_next;

    logic [7:0]  rx_byte, rx_data;
    logic        rx_done, rx_valid, overrun;
    logic [31:0] status;
    logic        tx_last, tx_free, req, accept_wr, accept_rd, clear_flags;
    logic        unused_bits;

    assign unused_bits = ^{uart_addr, uart_wdata[31:8]};

    uart_rx u_rx (
        .clock (clock),
        .reset (reset),
        .rx    (uart_rx),
        .data  (rx_byte),
        .done  (rx_done)
    );

    // A write may land in the last STOP cycle so back-to-back frames abut.
    assign tx_last     = (tx_cnt == bit_last);
    assign tx_free     = (tx_state == IDLE) || (tx_state == STOP && tx_last);
    assign req         = uart_valid && !uart_ready;
    assign accept_wr   = req && (|uart_wstrb) && tx_free;
    assign accept_rd   = req && !(|uart_wstrb);
    assign clear_flags = accept_rd && !uart_instr;

    always_comb begin
        status        = '0;
        status[7:0]   = rx_data;
        status[RXV]   = rx_valid;
        status[TXB]   = (tx_state != IDLE);
        status[OVR]   = overrun;
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt + 1'b1;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        unique case (tx_state)
            IDLE: tx_cnt_next = '0;
            START: begin
                if (tx_last) begin
                    tx_state_next = DATA;
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                end
            end
            DATA: begin
                if (tx_last) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = {1'b0, tx_shift[7:1]};
                    tx_bit_next   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_next = STOP;
                end
            end
            STOP: begin
                if (tx_last) begin
                    tx_state_next = IDLE;
                    tx_cnt_next   = '0;
                end
            end
            default: tx_state_next = IDLE;
        endcase
        if (accept_wr) begin
            tx_state_next = START;
            tx_cnt_next   = '0;
            tx_shift_next = uart_wdata[7:0];
        end
        unique case (tx_state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = tx_shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state   <= IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            uart_tx    <= 1'b1;
            uart_ready <= 1'b0;
            uart_rdata <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            tx_state   <= tx_state_next;
            tx_cnt     <= tx_cnt_next;
            tx_bit     <= tx_bit_next;
            tx_shift   <= tx_shift_next;
            uart_tx    <= tx_next;
            uart_ready <= accept_wr || accept_rd;
            if (accept_rd) uart_rdata <= uart_instr ? 32'd0 : status;
            if (clear_flags) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            // A byte completing under a read's clear survives; the read sees old data.
            if (rx_done) begin
                rx_data  <= rx_byte;
                rx_valid <= 1'b1;
                if (rx_valid && !clear_flags) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- Memory-mapped UART peripheral decoded in the window uart_base_addr..uart_top_addr (one 32-bit word).
- Consumes the shared configuration constants clks_per_bit and the UART address map.
- Sits between the core's data-memory bus and the board pins: bytes written by the core are serialised on tx; bytes arriving on rx are deframed and held for the core to read.
- 8N1 framing, LSB first, fixed baud of clk_freq/baudrate.

Parameters:
- clks_per_bit, 172 (configure::clks_per_bit), cycles per bit minus 1; every bit period is clks_per_bit+1 = 173 clocks.

Ports:
- reset  input  1  asynchronous, active-low reset
- clock  input  1  system clock
- uart_valid  input  1  bus request, already address-decoded
- uart_instr  input  1  instruction fetch flag; fetches read 0 and do not clear flags
- uart_addr  input  32  byte address; ignored beyond decode
- uart_wdata  input  32  write data; [7:0] is the TX byte
- uart_wstrb  input  4  byte strobes; nonzero = write, zero = read
- uart_rdata  output  32  read data
- uart_ready  output  1  one-cycle completion pulse
- uart_rx  input  1  serial input, asynchronous to clock
- uart_tx  output  1  serial output, idles high

Behaviour:
- Reset values:
  - uart_tx=1, uart_ready=0, uart_rdata=0.
  - TX and RX FSMs in IDLE; all counters 0.
  - rx_valid=0, overrun=0.
  - Reset asserted mid-frame aborts immediately: tx driven high, any partial RX byte discarded.
- Read data format (returned on every read):
  - [7:0]=rx_data, [8]=rx_valid, [9]=tx_busy, [10]=overrun, [31:11]=0.
- Bus timing: uart_ready pulses exactly one cycle, registered, never before the cycle after uart_valid rises. The requester holds uart_valid until it sees ready.
- Reads:
  - ready the cycle after valid.
  - In the ready cycle rx_valid and overrun clear (data reads only, not uart_instr).
- Writes:
  - If TX is IDLE: latch wdata[7:0], start the frame, ready the next cycle.
  - If TX is busy: ready is withheld until TX returns to IDLE, then the byte is accepted with ready one cycle later (write stalls the bus).
- TX FSM, IDLE -> START -> DATA -> STOP -> IDLE:
  - Each state holds one bit period: the counter counts 0..clks_per_bit, then the state advances.
  - START drives 0.
  - DATA drives shift[0] for 8 periods, LSB first, with a bit index 0..7.
  - STOP drives 1.
  - tx_busy = state != IDLE.
  - A frame is exactly 10*(clks_per_bit+1) = 1730 clocks from the acceptance cycle.
  - A write accepted in the same cycle STOP ends starts the next START with no idle gap.
- RX synchroniser: two flops on uart_rx; all RX logic uses the second flop.
- RX FSM, IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: a synchronised 1->0 transition enters START with counter 0.
  - START: at counter == clks_per_bit/2 (86), resample; if 1 it is a glitch, return to IDLE; if 0, reset the counter and enter DATA.
  - DATA: sample at each counter == clks_per_bit (mid-bit), LSB first, 8 bits.
  - STOP: sample at mid-bit.
    - If 1: load rx_data and set rx_valid; if rx_valid was already 1, also set overrun.
    - If 0 (framing error): discard the byte, flags unchanged.
    - Either way return to IDLE.
- Simultaneous events:
  - If RX completion and a read's clear occur in the same cycle, the new byte wins: rx_valid stays 1, the read returns the old data, and overrun is cleared by the read.
  - A write and a read cannot overlap; a single bus is assumed.
- Arithmetic: the bit counter is $clog2(clks_per_bit+1) bits wide and saturates at nothing; it wraps only via explicit reset to 0.

Decomposition:
- Package configure: clks_per_bit, uart_base_addr, uart_top_addr (already present).
- Same package gains:
  - the uart_state_t enum {IDLE, START, DATA, STOP}, shared by both FSMs;
  - read-field positions for RXV=8, TXB=9, OVR=10.
- One sub-module, uart_rx: synchroniser plus RX FSM; outputs a byte plus a one-cycle done pulse.
- TX FSM and bus logic stay in uart.

Test Plan:
- Write 0x55 when idle -> ready 1 cycle later; uart_tx is low for 173 clocks, then 1,0,1,0,1,0,1,0 each 173 clocks, then high; tx_busy reads 1 during the frame.
- Two back-to-back writes 0xA5, 0x3C -> second ready withheld until the first STOP completes; second START begins with no idle gap; total 3460 clocks.
- Drive an rx frame 0xC3 at 173 clocks/bit -> after STOP mid-sample, a read returns rdata=0x1C3; a second read returns 0x0C3.
- Two rx frames 0x11, 0x22 without a read -> read returns 0x522 (overrun and rx_valid set); next read 0x022.
- rx low pulse of 40 clocks -> START resample sees 1, no byte, rx_valid stays 0; a frame with stop bit 0 -> discarded, flags unchanged.
- Assert reset 500 clocks into a TX frame -> uart_tx=1 immediately, tx_busy=0 after release; a new write is accepted next cycle.
